// File: rtl/tick_pwm_pkg.sv
// tick_pwm_pkg: shared types and constants for the tick-driven PWM generator.
package tick_pwm_pkg;

   // Run state of the PWM engine
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      STOP = 2'd2
   } state_t;

   // Bit positions of the clock-divider taps inside div_tap; also the sel encoding
   localparam logic [1:0] TAP_DIV2  = 2'd0;
   localparam logic [1:0] TAP_DIV4  = 2'd1;
   localparam logic [1:0] TAP_DIV8  = 2'd2;
   localparam logic [1:0] TAP_DIV16 = 2'd3;

   localparam int NUM_TAPS = 4;

endpackage

// File: rtl/tap_edge_detect.sv
// tap_edge_detect: registered rising-edge detector for the four divider taps.
// o_rise is high in the cycle a tap is seen high after being low the cycle before.
module tap_edge_detect
   import tick_pwm_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic [NUM_TAPS-1:0] i_tap,
   output logic [NUM_TAPS-1:0] o_rise
);

   logic [NUM_TAPS-1:0] r_tap_q;

   // Previous-cycle copy of the taps
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_tap_q <= '0;
      else     r_tap_q <= i_tap;
   end

   assign o_rise = i_tap & ~r_tap_q;

endmodule

// File: rtl/tick_pwm_gen.sv
// tick_pwm_gen: selects one divider tap as step rate and drives a CW-bit PWM.
// Duty and rate changes are applied only at period wraps (or while idle) so a
// period is never truncated. Optional sticky interrupt: define TICK_PWM_IRQ_EN
// to add the irq/irq_clr ports.
module tick_pwm_gen
   import tick_pwm_pkg::*;
#(
   parameter int CW = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NUM_TAPS-1:0] div_tap,
   input  logic [1:0]          sel,
   input  logic                en,
   input  logic                duty_valid,
   input  logic [CW-1:0]       duty,
   output logic                duty_ready,
   output logic                tick,
   output logic                pwm_out,
   output logic                period_done
`ifdef TICK_PWM_IRQ_EN
   ,
   output logic                irq,
   input  logic                irq_clr
`endif
);

   localparam logic [CW-1:0] CNT_MAX = '1;

   state_t              r_state, w_state_nxt;
   logic [CW-1:0]       r_cnt, w_cnt_nxt;
   logic [CW-1:0]       r_duty_act, w_duty_nxt;
   logic [CW-1:0]       r_shadow;
   logic                r_full;
   logic [1:0]          r_sel_act;
   logic                r_tick, r_pwm, r_pd;
   logic [NUM_TAPS-1:0] w_rise;
   logic                w_run, w_adv, w_wrap, w_apply, w_accept, w_pwm_nxt;

   tap_edge_detect u_edge (
      .clk    (clk),
      .rst    (rst),
      .i_tap  (div_tap),
      .o_rise (w_rise)
   );

   assign w_run    = (r_state != IDLE);
   assign w_adv    = r_tick & w_run;
   assign w_wrap   = w_adv & (r_cnt == CNT_MAX);
   // Shadow duty and rate select are committed at a wrap, or freely while idle
   assign w_apply  = w_wrap | ~w_run;
   assign w_accept = duty_valid & ~r_full;

   // Next run state; a STOP that sees en again resumes without restarting the period
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (en) w_state_nxt = RUN;
         RUN:     if (!en) w_state_nxt = STOP;
         STOP: begin
            if (en)          w_state_nxt = RUN;
            else if (w_wrap) w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Next counter value; held at zero while idle
   always_comb begin
      w_cnt_nxt = r_cnt;
      if (!w_run)     w_cnt_nxt = '0;
      else if (w_adv) w_cnt_nxt = r_cnt + 1'b1;
   end

   assign w_duty_nxt = (w_apply & r_full) ? r_shadow : r_duty_act;
   // PWM computed from next-state values so it lines up with the counter
   assign w_pwm_nxt  = (w_state_nxt != IDLE) && (w_cnt_nxt < w_duty_nxt);

   // Core state: FSM, counter, active duty/rate and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= IDLE;
         r_cnt      <= '0;
         r_duty_act <= '0;
         r_sel_act  <= TAP_DIV2;
         r_tick     <= 1'b0;
         r_pwm      <= 1'b0;
         r_pd       <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_cnt      <= w_cnt_nxt;
         r_duty_act <= w_duty_nxt;
         if (w_apply) r_sel_act <= sel;
         r_tick     <= w_run & w_rise[r_sel_act];
         r_pwm      <= w_pwm_nxt;
         r_pd       <= w_wrap;
      end
   end

   // Duty shadow register; an accept always targets an empty shadow, so it
   // never collides with the commit that empties it
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_full   <= 1'b0;
         r_shadow <= '0;
      end else if (w_accept) begin
         r_full   <= 1'b1;
         r_shadow <= duty;
      end else if (w_apply) begin
         r_full   <= 1'b0;
      end
   end

   assign duty_ready  = ~r_full;
   assign tick        = r_tick;
   assign pwm_out     = r_pwm;
   assign period_done = r_pd;

`ifdef TICK_PWM_IRQ_EN
   logic r_irq;

   // Sticky period interrupt; a set in the same cycle as a clear wins
   always_ff @(posedge clk or posedge rst) begin
      if (rst)          r_irq <= 1'b0;
      else if (w_wrap)  r_irq <= 1'b1;
      else if (irq_clr) r_irq <= 1'b0;
   end

   assign irq = r_irq;
`endif

endmodule

// File: tb/tb_tick_pwm_gen.sv
// tb_tick_pwm_gen: scenario tasks plus randomized traffic, checked against a
// behavioural model that works from tap-counter arithmetic rather than edges.
module tb_tick_pwm_gen;

   localparam int CW   = 4;
   localparam int MAXC = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [3:0]    div_tap = 4'd0;
   logic [1:0]    sel = 2'd0;
   logic          en = 1'b0;
   logic          duty_valid = 1'b0;
   logic [CW-1:0] duty = '0;
   logic          duty_ready, tick, pwm_out, period_done;
   logic          clr_in = 1'b0;
`ifdef TICK_PWM_IRQ_EN
   logic          irq;
`endif

   int checks = 0;
   int errors = 0;

   tick_pwm_gen #(.CW(CW)) dut (
      .clk         (clk),
      .rst         (rst),
      .div_tap     (div_tap),
      .sel         (sel),
      .en          (en),
      .duty_valid  (duty_valid),
      .duty        (duty),
      .duty_ready  (duty_ready),
      .tick        (tick),
      .pwm_out     (pwm_out),
      .period_done (period_done)
`ifdef TICK_PWM_IRQ_EN
      ,
      .irq         (irq),
      .irq_clr     (clr_in)
`endif
   );

   always #5 clk = ~clk;

   // Free-running divider counter, advanced away from the sampling edge
   always @(negedge clk) div_tap = div_tap + 4'd1;

   // ---------------- reference model ----------------
   typedef struct {
      int st;      // 0 idle, 1 run, 2 stop
      int cnt;
      int dty;
      int rate;
      int shadow;
      bit full;
      bit tck;
      bit pwm;
      bit pd;
      bit irq;
   } mdl_t;

   mdl_t m;

   function automatic mdl_t model_step(mdl_t s, int tap, int sel_i, bit en_i,
                                       bit dv, int dval, bit clr);
      mdl_t n = s;
      bit counting = (s.st != 0) && s.tck;
      bit wrap     = counting && (s.cnt == MAXC);
      bit commit   = wrap || (s.st == 0);
      // tap k rises exactly when the counter's low k+1 bits read 1000..0
      n.tck = (s.st != 0) && ((tap % (2 << s.rate)) == (1 << s.rate));
      if (en_i)          n.st = 1;
      else if (s.st == 1) n.st = 2;
      else if (s.st == 2) n.st = wrap ? 0 : 2;
      else               n.st = 0;
      n.cnt = (s.st == 0) ? 0 : (counting ? (s.cnt + 1) % (MAXC + 1) : s.cnt);
      if (commit && s.full) n.dty = s.shadow;
      if (commit) n.rate = sel_i;
      if (dv && !s.full) begin
         n.full = 1'b1;
         n.shadow = dval;
      end else if (commit) begin
         n.full = 1'b0;
      end
      n.pd  = wrap;
      n.pwm = (n.st != 0) && (n.cnt < n.dty);
      if (wrap)     n.irq = 1'b1;
      else if (clr) n.irq = 1'b0;
      return n;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) m <= '{default: 0};
      else     m <= model_step(m, int'(div_tap), int'(sel), en, duty_valid, int'(duty), clr_in);
   end

   // ---------------- scenarios ----------------
   task automatic test_reset();
      int n;
      checks++;
      if ({tick, pwm_out, period_done, duty_ready} !== 4'b0001) begin
         errors++; $display("FAIL reset_hold got %b want 0001", {tick, pwm_out, period_done, duty_ready});
      end
      @(negedge clk); rst = 1'b0; sel = 2'd0; en = 1'b1;
      n = 0;
      do begin
         @(negedge clk); n++; checks++;
         if ({tick, pwm_out, period_done, duty_ready} !== {m.tck, m.pwm, m.pd, !m.full}) begin
            errors++; $display("FAIL reset_run @%0t got %b want %b", $time, {tick, pwm_out, period_done, duty_ready}, {m.tck, m.pwm, m.pd, !m.full});
         end
         if (m.cnt == 3 && duty_ready) begin duty_valid = 1'b1; duty = 4'd9; end
         else duty_valid = 1'b0;
      end while (m.cnt != 7 && n < 100);
      duty_valid = 1'b0;
      checks++;
      if (m.cnt != 7) begin errors++; $display("FAIL reset_reach7 timeout cnt %0d want 7", m.cnt); end
      checks++;
      if (duty_ready !== 1'b0) begin errors++; $display("FAIL reset_shadow_full got %b want 0", duty_ready); end
      #3 rst = 1'b1;
      #1 checks++;
      if ({tick, pwm_out, period_done, duty_ready} !== 4'b0001) begin
         errors++; $display("FAIL reset_async got %b want 0001", {tick, pwm_out, period_done, duty_ready});
      end
      en = 1'b0;
      @(negedge clk); rst = 1'b0;
      repeat (12) begin
         @(negedge clk); checks++;
         if ({tick, pwm_out, period_done, duty_ready} !== 4'b0001) begin
            errors++; $display("FAIL reset_idle got %b want 0001", {tick, pwm_out, period_done, duty_ready});
         end
      end
   endtask

   task automatic test_basic();
      int n, hi, tk, pdc;
      duty_valid = 1'b1; duty = 4'd4; sel = 2'd0;
      @(negedge clk); duty_valid = 1'b0;
      @(negedge clk); en = 1'b1;
      n = 0;
      do begin
         @(negedge clk); n++; checks++;
         if ({tick, pwm_out, period_done, duty_ready} !== {m.tck, m.pwm, m.pd, !m.full}) begin
            errors++; $display("FAIL basic_run @%0t got %b want %b", $time, {tick, pwm_out, period_done, duty_ready}, {m.tck, m.pwm, m.pd, !m.full});
         end
      end while (!m.pd && n < 100);
      hi = int'(pwm_out); tk = int'(tick); pdc = int'(period_done);
      repeat (31) begin
         @(negedge clk); checks++;
         if ({tick, pwm_out, period_done, duty_ready} !== {m.tck, m.pwm, m.pd, !m.full}) begin
            errors++; $display("FAIL basic_win @%0t got %b want %b", $time, {tick, pwm_out, period_done, duty_ready}, {m.tck, m.pwm, m.pd, !m.full});
         end
         hi += int'(pwm_out); tk += int'(tick); pdc += int'(period_done);
      end
      checks++; if (hi != 8)  begin errors++; $display("FAIL basic_high got %0d want 8", hi); end
      checks++; if (tk != 16) begin errors++; $display("FAIL basic_ticks got %0d want 16", tk); end
      checks++; if (pdc != 1) begin errors++; $display("FAIL basic_pd got %0d want 1", pdc); end
      @(negedge clk); checks++;
      if (period_done !== 1'b1) begin errors++; $display("FAIL basic_pd32 got %b want 1", period_done); end
   endtask

   task automatic test_duty_update();
      int n, hi;
      n = 0;
      do begin
         @(negedge clk); n++; checks++;
         if ({tick, pwm_out, period_done, duty_ready} !== {m.tck, m.pwm, m.pd, !m.full}) begin
            errors++; $display("FAIL duty_wait @%0t got %b want %b", $time, {tick, pwm_out, period_done, duty_ready}, {m.tck, m.pwm, m.pd, !m.full});
         end
      end while (m.cnt != 5 && n < 100);
      duty_valid = 1'b1; duty = 4'd12;
      @(negedge clk); duty = 4'($urandom_range(1, 11));
      checks++;
      if (duty_ready !== 1'b0) begin errors++; $display("FAIL duty_accept ready %b want 0", duty_ready); end
      repeat (4) begin
         @(negedge clk); checks++;
         if (duty_ready !== 1'b0) begin errors++; $display("FAIL duty_busy ready %b want 0", duty_ready); end
      end
      duty_valid = 1'b0;
      hi = 0; n = 0;
      do begin
         @(negedge clk); n++; checks++;
         if ({tick, pwm_out, period_done, duty_ready} !== {m.tck, m.pwm, m.pd, !m.full}) begin
            errors++; $display("FAIL duty_tail @%0t got %b want %b", $time, {tick, pwm_out, period_done, duty_ready}, {m.tck, m.pwm, m.pd, !m.full});
         end
         if (!m.pd) hi += int'(pwm_out);
      end while (!m.pd && n < 100);
      checks++; if (hi != 0) begin errors++; $display("FAIL duty_old_tail high %0d want 0", hi); end
      checks++; if (duty_ready !== 1'b1) begin errors++; $display("FAIL duty_ready_back got %b want 1", duty_ready); end
      for (int p = 0; p < 2; p++) begin
         if (p == 1) @(negedge clk);
         hi = int'(pwm_out);
         repeat (31) begin
            @(negedge clk); checks++;
            if ({tick, pwm_out, period_done, duty_ready} !== {m.tck, m.pwm, m.pd, !m.full}) begin
               errors++; $display("FAIL duty_win @%0t got %b want %b", $time, {tick, pwm_out, period_done, duty_ready}, {m.tck, m.pwm, m.pd, !m.full});
            end
            hi += int'(pwm_out);
         end
         checks++; if (hi != 24) begin errors++; $display("FAIL duty_new_high p%0d got %0d want 24", p, hi); end
      end
   endtask

   task automatic test_rate();
      int n, last, cnt;
      n = 0;
      do begin @(negedge clk); n++; end while (m.cnt != 5 && n < 100);
      sel = 2'd3;
      last = -1; n = 0;
      do begin
         @(negedge clk); n++;
         if (tick) begin
            checks++;
            if (last >= 0 && n - last != 2) begin errors++; $display("FAIL rate_old_gap got %0d want 2", n - last); end
            last = n;
         end
      end while (!m.pd && n < 100);
      sel = 2'd0;  // takes effect only at the next wrap
      last = -1; n = 0; cnt = 0;
      do begin
         @(negedge clk); n++; checks++;
         if ({tick, pwm_out, period_done, duty_ready} !== {m.tck, m.pwm, m.pd, !m.full}) begin
            errors++; $display("FAIL rate_run @%0t got %b want %b", $time, {tick, pwm_out, period_done, duty_ready}, {m.tck, m.pwm, m.pd, !m.full});
         end
         if (tick) begin
            cnt++;
            if (last >= 0) begin
               checks++;
               if (n - last != 16) begin errors++; $display("FAIL rate_new_gap got %0d want 16", n - last); end
            end
            last = n;
         end
      end while (!m.pd && n < 400);
      checks++; if (cnt != 16) begin errors++; $display("FAIL rate_ticks got %0d want 16", cnt); end
   endtask

   task automatic test_stop();
      int n, tk, hi;
      for (int pass = 0; pass < 2; pass++) begin
         en = 1'b1; n = 0;
         do begin @(negedge clk); n++; end while (m.cnt != 9 && n < 200);
         en = 1'b0;
         if (pass == 1) begin
            n = 0;
            do begin @(negedge clk); n++; end while (m.cnt != 12 && n < 100);
            en = 1'b1;
         end
         tk = 0; n = 0;
         do begin
            @(negedge clk); n++; checks++;
            if ({tick, pwm_out, period_done, duty_ready} !== {m.tck, m.pwm, m.pd, !m.full}) begin
               errors++; $display("FAIL stop_run p%0d @%0t got %b want %b", pass, $time, {tick, pwm_out, period_done, duty_ready}, {m.tck, m.pwm, m.pd, !m.full});
            end
            tk += int'(tick);
         end while (!m.pd && n < 100);
         if (pass == 0) begin
            checks++; if (tk != 7) begin errors++; $display("FAIL stop_ticks got %0d want 7", tk); end
         end
         tk = 0; hi = 0;
         repeat (20) begin
            @(negedge clk); tk += int'(tick); hi += int'(pwm_out);
         end
         checks++;
         if (pass == 0 && (tk != 0 || hi != 0)) begin
            errors++; $display("FAIL stop_idle ticks %0d high %0d want 0 0", tk, hi);
         end else if (pass == 1 && tk != 10) begin
            errors++; $display("FAIL resume_ticks got %0d want 10", tk);
         end
      end
   endtask

   task automatic test_boundary();
      int n, hi;
      en = 1'b1;
      @(negedge clk); duty_valid = 1'b1; duty = 4'd0;
      @(negedge clk); duty_valid = 1'b0;
      n = 0;
      do begin @(negedge clk); n++; end while (!m.pd && n < 100);
      duty_valid = 1'b1; duty = 4'd15;
      for (int p = 0; p < 2; p++) begin
         if (p == 1) @(negedge clk);
         hi = int'(pwm_out);
         repeat (31) begin
            @(negedge clk); duty_valid = 1'b0; checks++;
            if ({tick, pwm_out, period_done, duty_ready} !== {m.tck, m.pwm, m.pd, !m.full}) begin
               errors++; $display("FAIL bound_win @%0t got %b want %b", $time, {tick, pwm_out, period_done, duty_ready}, {m.tck, m.pwm, m.pd, !m.full});
            end
            hi += int'(pwm_out);
         end
         checks++;
         if (hi != (p == 0 ? 0 : 30)) begin errors++; $display("FAIL bound_high p%0d got %0d want %0d", p, hi, p == 0 ? 0 : 30); end
      end
   endtask

`ifdef TICK_PWM_IRQ_EN
   task automatic test_irq();
      int n;
      @(negedge clk); clr_in = 1'b1;
      @(negedge clk); clr_in = 1'b0; checks++;
      if (irq !== 1'b0) begin errors++; $display("FAIL irq_clear got %b want 0", irq); end
      for (int p = 0; p < 2; p++) begin
         n = 0;
         do begin @(negedge clk); n++; end while (!(m.tck && m.st != 0 && m.cnt == MAXC) && n < 100);
         checks++;
         if (p == 0 && irq !== 1'b0) begin errors++; $display("FAIL irq_early got %b want 0", irq); end
         clr_in = (p == 1);
         @(negedge clk); clr_in = 1'b0; checks++;
         if ({period_done, irq} !== 2'b11) begin errors++; $display("FAIL irq_set p%0d got %b want 11", p, {period_done, irq}); end
      end
   endtask
`endif

   task automatic test_random();
      repeat (900) begin
         @(negedge clk); checks++;
         if ({tick, pwm_out, period_done, duty_ready} !== {m.tck, m.pwm, m.pd, !m.full}) begin
            errors++; $display("FAIL rand @%0t got %b want %b", $time, {tick, pwm_out, period_done, duty_ready}, {m.tck, m.pwm, m.pd, !m.full});
         end
         if ($urandom_range(0, 39) == 0) en = ~en;
         if ($urandom_range(0, 59) == 0) sel = 2'($urandom_range(0, 3));
         duty_valid = ($urandom_range(0, 7) == 0);
         duty = 4'($urandom);
      end
      duty_valid = 1'b0;
   endtask

   initial begin
      repeat (3) @(negedge clk);
      test_reset();
      test_basic();
      test_duty_update();
      test_rate();
      test_stop();
      test_boundary();
`ifdef TICK_PWM_IRQ_EN
      test_irq();
`endif
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
